// File: rtl/single_regfile_pkg.sv
// Shared widths and constants for the CPU register file.
package single_regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/single_regfile_if.sv
// Read/write/debug bus between the datapath and the register file.
interface single_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    import single_regfile_pkg::*;

    logic [ADDR_W-1:0] i_ra;
    logic [ADDR_W-1:0] i_rb;
    logic [DATA_W-1:0] o_rda;
    logic [DATA_W-1:0] o_rdb;
    logic              i_we;
    logic [ADDR_W-1:0] i_wa;
    logic [DATA_W-1:0] i_wd;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] o_dbg_data;
    logic [CNT_W-1:0]  o_wr_cnt;

    modport master (
        output i_ra, i_rb, i_we, i_wa, i_wd, i_dbg_addr,
        input  o_rda, o_rdb, o_dbg_data, o_wr_cnt
    );

    modport slave (
        input  i_ra, i_rb, i_we, i_wa, i_wd, i_dbg_addr,
        output o_rda, o_rdb, o_dbg_data, o_wr_cnt
    );

endinterface

// File: rtl/single_regfile_rdport.sv
// One combinational read port: zero-register rule, optional write bypass, then stored value.
module single_regfile_rdport
    import single_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              byp_we,
    input  logic [ADDR_W-1:0] byp_wa,
    input  logic [DATA_W-1:0] byp_wd,
    output logic [DATA_W-1:0] data
);

    logic is_zero;
    logic byp_hit;

    assign is_zero = (addr == ADDR_W'(REG_ZERO));
    assign byp_hit = BYPASS && byp_we && (byp_wa == addr);

    always_comb begin
        data = regs[addr];
        if (is_zero) begin
            data = '0;
        end else if (byp_hit) begin
            data = byp_wd;
        end
    end

endmodule

// File: rtl/single_regfile.sv
// 2**ADDR_W x DATA_W register file, r0 hardwired to zero, with a saturating write counter.
module single_regfile
    import single_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    single_regfile_if.slave bus
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d;
    logic              wr_hit;
    logic              byp_we;

    assign wr_hit = bus.i_we && (bus.i_wa != ADDR_W'(REG_ZERO));
    // Bypass is suppressed during reset so reads stay at zero.
    assign byp_we = bus.i_we && !i_rst;

    always_comb begin
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        if (wr_hit) begin
            regs_d[bus.i_wa] = bus.i_wd;
            if (wr_cnt_q != CNT_MAX) begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign bus.o_wr_cnt = wr_cnt_q;

    single_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_a (
        .addr   (bus.i_ra),
        .regs   (regs_q),
        .byp_we (byp_we),
        .byp_wa (bus.i_wa),
        .byp_wd (bus.i_wd),
        .data   (bus.o_rda)
    );

    single_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd_b (
        .addr   (bus.i_rb),
        .regs   (regs_q),
        .byp_we (byp_we),
        .byp_wa (bus.i_wa),
        .byp_wd (bus.i_wd),
        .data   (bus.o_rdb)
    );

    single_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_rd_dbg (
        .addr   (bus.i_dbg_addr),
        .regs   (regs_q),
        .byp_we (byp_we),
        .byp_wa (bus.i_wa),
        .byp_wd (bus.i_wd),
        .data   (bus.o_dbg_data)
    );

endmodule

// File: tb/tb_single_regfile.sv
// Directed scoreboard bench: one bypassing and one non-bypassing register file driven in lockstep.
module tb_single_regfile;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    single_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    single_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    single_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .i_clk (i_clk), .i_rst (i_rst), .bus (bus1.slave)
    );
    single_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
        .i_clk (i_clk), .i_rst (i_rst), .bus (bus0.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t       sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = '0;
    logic        cur_we  = 1'b0;
    logic [4:0]  cur_wa  = '0;

    function automatic logic [31:0] alu(input logic [31:0] r, input logic [31:0] s,
                                        input logic [2:0] aluc);
        case (aluc)
            3'b110:  alu = r - s;
            3'b111:  alu = ($signed(r) < $signed(s)) ? 32'd1 : 32'd0;
            default: alu = r + s;
        endcase
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dbg);
        bus1.i_we = we; bus1.i_wa = wa; bus1.i_wd = wd;
        bus1.i_ra = ra; bus1.i_rb = rb; bus1.i_dbg_addr = dbg;
        bus0.i_we = we; bus0.i_wa = wa; bus0.i_wd = wd;
        bus0.i_ra = ra; bus0.i_rb = rb; bus0.i_dbg_addr = dbg;
        cur_we = we; cur_wa = wa;
    endtask

    // Counter model follows each committed edge.
    task automatic tick();
        @(posedge i_clk);
        if (!i_rst && cur_we && cur_wa != 5'd0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        item_t it;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", it.tag, obs, it.exp);
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        int          n_fill;

        i_rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        #12;
        push("rst_cnt1", 32'd0); push("rst_cnt0", 32'd0); push("rst_rda1", 32'd0);
        pop_cmp(32'(bus1.o_wr_cnt)); pop_cmp(32'(bus0.o_wr_cnt)); pop_cmp(bus1.o_rda);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Preload reg 5, then assert reset between edges.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd5, 32'd0, 5'd5, 5'd5, 5'd5);
        push("preload_rda", 32'hDEADBEEF); push("preload_cnt", 32'(exp_cnt));
        #1;
        pop_cmp(bus0.o_rda); pop_cmp(32'(bus0.o_wr_cnt));
        #2;
        i_rst = 1'b1;
        exp_cnt = '0;
        push("async_rst_rda1", 32'd0); push("async_rst_rda0", 32'd0);
        push("async_rst_dbg", 32'd0);  push("async_rst_cnt", 32'd0);
        #1;
        pop_cmp(bus1.o_rda); pop_cmp(bus0.o_rda); pop_cmp(bus1.o_dbg_data); pop_cmp(32'(bus1.o_wr_cnt));

        // A write while reset is held must be lost and must not bypass.
        drive(1'b1, 5'd6, 32'h000000AA, 5'd6, 5'd6, 5'd6);
        push("rst_no_bypass", 32'd0);
        #1;
        pop_cmp(bus1.o_rda);
        tick();
        @(negedge i_clk);
        i_rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd6, 5'd6);
        push("rst_write_lost", 32'd0); push("rst_write_cnt", 32'd0);
        #1;
        pop_cmp(bus0.o_rda); pop_cmp(32'(bus0.o_wr_cnt));

        // Basic write/read.
        @(negedge i_clk);
        drive(1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        push("basic_rda1", 32'h12345678); push("basic_rdb0", 32'h12345678);
        push("basic_cnt", 32'd1);
        #1;
        pop_cmp(bus1.o_rda); pop_cmp(bus0.o_rdb); pop_cmp(32'(bus1.o_wr_cnt));

        // Register 0 write ignored and never bypassed.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        push("zero_bypass", 32'd0);
        #1;
        pop_cmp(bus1.o_rda);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        push("zero_rda", 32'd0); push("zero_cnt", 32'd1);
        #1;
        pop_cmp(bus0.o_rda); pop_cmp(32'(bus0.o_wr_cnt));

        // Bypass versus non-bypass on reg 7.
        drive(1'b1, 5'd7, 32'd1, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'd9, 5'd7, 5'd7, 5'd7);
        push("byp_rda", 32'd9); push("byp_rdb", 32'd9); push("byp_dbg", 32'd1);
        push("nob_rda", 32'd1); push("nob_rdb", 32'd1); push("nob_dbg", 32'd1);
        #1;
        pop_cmp(bus1.o_rda); pop_cmp(bus1.o_rdb); pop_cmp(bus1.o_dbg_data);
        pop_cmp(bus0.o_rda); pop_cmp(bus0.o_rdb); pop_cmp(bus0.o_dbg_data);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        push("post_edge_nob", 32'd9); push("post_edge_cnt", 32'(exp_cnt));
        #1;
        pop_cmp(bus0.o_rda); pop_cmp(32'(bus0.o_wr_cnt));

        // Ports bypass independently.
        drive(1'b1, 5'd8, 32'h00000055, 5'd8, 5'd3, 5'd8);
        push("indep_rda", 32'h00000055); push("indep_rdb", 32'h12345678); push("indep_dbg", 32'd0);
        #1;
        pop_cmp(bus1.o_rda); pop_cmp(bus1.o_rdb); pop_cmp(bus1.o_dbg_data);
        tick();

        // ALU pairing: SUB then SLT on reg1/reg2.
        drive(1'b1, 5'd1, 32'd7, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd2, 32'd7, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd0);
        push("alu_sub", 32'd0); push("alu_zero", 32'd1);
        #1;
        res = alu(bus0.o_rda, bus0.o_rdb, 3'b110);
        pop_cmp(res); pop_cmp(32'(res == 32'd0));
        drive(1'b1, 5'd2, 32'd8, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd0);
        push("alu_slt", 32'd1);
        #1;
        pop_cmp(alu(bus1.o_rda, bus1.o_rdb, 3'b111));

        // Counter saturation via repeated writes to reg 4.
        n_fill = int'(16'hFFFE) - int'(exp_cnt);
        drive(1'b1, 5'd4, 32'h0000CAFE, 5'd4, 5'd4, 5'd4);
        repeat (n_fill) tick();
        push("cnt_fffe", 32'h0000FFFE);
        pop_cmp(32'(bus1.o_wr_cnt));
        tick();
        push("cnt_ffff", 32'h0000FFFF); push("cnt_ffff_nob", 32'h0000FFFF);
        pop_cmp(32'(bus1.o_wr_cnt)); pop_cmp(32'(bus0.o_wr_cnt));
        tick();
        push("cnt_sat", 32'h0000FFFF); push("cnt_model", 32'(exp_cnt));
        pop_cmp(32'(bus1.o_wr_cnt)); pop_cmp(32'(bus0.o_wr_cnt));
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 5'd4);
        push("reg4_data", 32'h0000CAFE);
        #1;
        pop_cmp(bus0.o_dbg_data);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/single_regfile.md
Name: single_regfile

Overview:
- General-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU: read port A drives ALU operand i_r; read port B drives the operand-select mux that feeds ALU i_s.
- Write port accepts the writeback value (ALU result or memory load data) at the clock edge.
- 32 x 32-bit registers; register 0 hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded onto matching read ports; 0 = reads return stored value only.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_ra  input  ADDR_W  read address A (rs field).
- i_rb  input  ADDR_W  read address B (rt field).
- o_rda  output  DATA_W  read data A; drives ALU i_r.
- o_rdb  output  DATA_W  read data B; drives ALU i_s via operand mux, also store data.
- i_we  input  1  write enable.
- i_wa  input  ADDR_W  write address (rd/rt field).
- i_wd  input  DATA_W  write data (writeback value).
- i_dbg_addr  input  ADDR_W  debug/display read address.
- o_dbg_data  output  DATA_W  debug read data; never bypassed.
- o_wr_cnt  output  16  count of committed writes to non-zero registers; saturates at 16'hFFFF.

Behaviour:
- Reset: i_rst high clears all registers to 0 and o_wr_cnt to 0 immediately (asynchronous), independent of i_clk. While i_rst is high, o_rda, o_rdb and o_dbg_data read 0 and writes are ignored.
- Reset mid-operation: a write presented in the same cycle reset asserts is lost. After reset deasserts, the first rising edge with i_we=1 commits normally.
- Write:
  - At rising edge of i_clk with i_we=1 and i_wa!=0: reg[i_wa] <= i_wd and o_wr_cnt increments by 1, saturating at 16'hFFFF (no wrap).
  - i_we=1 with i_wa=0: no state change, counter unchanged.
  - i_we=0: no state change.
- Read: combinational, zero latency. o_rda = reg[i_ra], o_rdb = reg[i_rb], o_dbg_data = reg[i_dbg_addr].
- Register 0: any read port addressing 0 returns 0 in every case, including bypass.
- Bypass (BYPASS=1): if i_we=1, i_wa!=0 and i_wa==i_ra, then o_rda = i_wd combinationally; same rule for port B independently. Both ports may bypass in the same cycle when i_ra==i_rb==i_wa.
- No bypass (BYPASS=0): reads show the old value until after the edge.
- Priority: reset > zero-register rule > bypass > stored value.
- Width rules:
  - No sign or zero extension; data stored and returned at DATA_W bits exactly.
  - Addresses are full-range; no out-of-range case exists.
- No combinational path from i_wd to outputs when BYPASS=0.

Decomposition:
- Shared package holds DATA_W and ADDR_W defaults, the REG_ZERO address constant (0), and the write-counter width (16) with its saturation value.
- The storage array and read muxes live in one module.
- A sub-module single_regfile_rdport (address in, array in, bypass inputs in, data out) is natural, instantiated three times with bypass disabled on the debug instance.

Test Plan:
- Reset: preload reg 5 = 32'hDEADBEEF, assert i_rst asynchronously between edges -> o_rda with i_ra=5 reads 0 at once; o_wr_cnt=0.
- Basic write/read: i_we=1, i_wa=3, i_wd=32'h12345678, edge -> i_ra=3 gives o_rda=32'h12345678; o_wr_cnt=1.
- Zero register: i_we=1, i_wa=0, i_wd=32'hFFFFFFFF, edge -> i_ra=0 reads 0; o_wr_cnt unchanged.
- Bypass: BYPASS=1, reg 7 = 1, i_we=1, i_wa=7, i_wd=9, i_ra=i_rb=7 before edge -> o_rda=o_rdb=9 immediately, o_dbg_data (addr 7)=1. Repeat with BYPASS=0 -> all read 1 until the edge.
- ALU pairing: write reg1=7, reg2=7, feed o_rda/o_rdb into the ALU with aluc=3'b110 -> ALU result 0, zero flag 1. Change reg2 to 8 -> aluc=3'b111 gives 1.
- Counter saturation: force o_wr_cnt to 16'hFFFE, two writes to reg 4 -> 16'hFFFF, stays 16'hFFFF.
